// File: rtl/omsp_irq_dispatcher.sv
// Interrupt dispatcher: latches IRQ/violation sources, arbitrates, runs the vector-fetch handshake.
// Optional dispatch-latency monitor enabled by defining SANCUS_IRQ_LAT_MON_EN.
module omsp_irq_dispatcher #(
    parameter int NR_IRQ    = 14,
    parameter int NUM_W     = $clog2(NR_IRQ + 1),
    parameter int FETCH_TMO = 15,
    parameter int CNT_W     = 16
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic [NR_IRQ-1:0] irq_in,
    input  logic              gie,
    input  logic              atom_violation,
    input  logic              inst_boundary,
    input  logic              vec_ack,
    output logic              irq_detect,
    output logic [NUM_W-1:0]  irq_num,
    output logic [NR_IRQ-1:0] irq_acc,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  irq_lat_max
);

    localparam int WD_W = $clog2(FETCH_TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DETECT,
        S_FETCH,
        S_ACK
    } state_t;

    state_t            r_state;
    logic [WD_W-1:0]   r_wdog;
    logic              r_viol_pend;
    logic              r_irq_detect;
    logic              r_fetch_err;
    logic [NUM_W-1:0]  r_irq_num;
    logic [NR_IRQ-1:0] r_irq_acc;

    logic [NUM_W-1:0]  w_hi_idx;
    logic              w_any_irq;
    logic [NR_IRQ-1:0] w_acc_mask;
    logic [WD_W-1:0]   w_wdog_nxt;
    logic              w_tmo;
    logic              w_viol_served;
    logic              w_accept_viol;
    logic              w_accept_irq;
    logic              w_accept;
    logic              w_abort;

    // Highest set index wins: later loop iterations override earlier ones.
    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < NR_IRQ; i++) begin
            if (irq_in[i]) begin
                w_hi_idx = NUM_W'(i);
            end
        end
    end

    always_comb begin
        w_acc_mask = '0;
        for (int i = 0; i < NR_IRQ; i++) begin
            w_acc_mask[i] = (r_irq_num == NUM_W'(i));
        end
    end

    assign w_any_irq     = |irq_in;
    assign w_viol_served = (r_irq_num == NUM_W'(NR_IRQ));
    assign w_wdog_nxt    = r_wdog + WD_W'(1);
    assign w_tmo         = (w_wdog_nxt == WD_W'(FETCH_TMO));

    assign w_accept_viol = (r_state == S_IDLE) && r_viol_pend && inst_boundary;
    assign w_accept_irq  = (r_state == S_IDLE) && !r_viol_pend && gie
                           && inst_boundary && w_any_irq;
    assign w_accept      = w_accept_viol || w_accept_irq;
    assign w_abort       = (r_state == S_FETCH) && !vec_ack && w_tmo;

    // A fresh violation always outranks clearing the served one.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_viol_pend <= 1'b0;
        end else if (atom_violation) begin
            r_viol_pend <= 1'b1;
        end else if (((r_state == S_ACK) || w_abort) && w_viol_served) begin
            r_viol_pend <= 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state      <= S_IDLE;
            r_wdog       <= '0;
            r_irq_num    <= '0;
            r_irq_detect <= 1'b0;
            r_irq_acc    <= '0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_irq_detect <= 1'b0;
            r_irq_acc    <= '0;
            r_fetch_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept_viol) begin
                        r_irq_num    <= NUM_W'(NR_IRQ);
                        r_irq_detect <= 1'b1;
                        r_state      <= S_DETECT;
                    end else if (w_accept_irq) begin
                        r_irq_num    <= w_hi_idx;
                        r_irq_detect <= 1'b1;
                        r_state      <= S_DETECT;
                    end
                end
                S_DETECT: begin
                    r_wdog  <= '0;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (vec_ack) begin
                        r_irq_acc <= w_acc_mask;
                        r_state   <= S_ACK;
                    end else begin
                        r_wdog <= w_wdog_nxt;
                        if (w_tmo) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq_detect = r_irq_detect;
    assign irq_num    = r_irq_num;
    assign irq_acc    = r_irq_acc;
    assign fetch_err  = r_fetch_err;

`ifdef SANCUS_IRQ_LAT_MON_EN
    logic [CNT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] r_lat_max;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_lat_cnt <= '0;
            r_lat_max <= '0;
        end else if (w_accept) begin
            if (r_lat_cnt > r_lat_max) begin
                r_lat_max <= r_lat_cnt;
            end
            r_lat_cnt <= '0;
        end else if ((r_state == S_IDLE) && (r_viol_pend || w_any_irq)
                     && (r_lat_cnt != '1)) begin
            r_lat_cnt <= r_lat_cnt + CNT_W'(1);
        end
    end

    assign irq_lat_max = r_lat_max;
`else
    assign irq_lat_max = '0;
`endif

endmodule

// File: tb/tb_omsp_irq_dispatcher.sv
// Directed self-checking bench for omsp_irq_dispatcher.
// Expected values are hand-derived from the dispatcher's cycle behaviour.
module tb_omsp_irq_dispatcher;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [13:0] irq_in = '0;
    logic        gie = 1'b0;
    logic        atom_violation = 1'b0;
    logic        inst_boundary = 1'b0;
    logic        vec_ack = 1'b0;
    logic        irq_detect;
    logic [3:0]  irq_num;
    logic [13:0] irq_acc;
    logic        fetch_err;
    logic [15:0] irq_lat_max;

    int n_cmp = 0;
    int n_err = 0;
    int bad;

    omsp_irq_dispatcher dut (
        .mclk           (mclk),
        .puc_rst_n      (puc_rst_n),
        .irq_in         (irq_in),
        .gie            (gie),
        .atom_violation (atom_violation),
        .inst_boundary  (inst_boundary),
        .vec_ack        (vec_ack),
        .irq_detect     (irq_detect),
        .irq_num        (irq_num),
        .irq_acc        (irq_acc),
        .fetch_err      (fetch_err),
        .irq_lat_max    (irq_lat_max)
    );

    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_detect", 32'(irq_detect), 32'd0);
        chk("rst_num", 32'(irq_num), 32'd0);
        chk("rst_acc", 32'(irq_acc), 32'd0);
        chk("rst_ferr", 32'(fetch_err), 32'd0);
        chk("rst_latmax", 32'(irq_lat_max), 32'd0);
        puc_rst_n = 1'b1;
        step();

        // Priority: bits 5 and 2 pending, 5 wins
        irq_in = 14'h0024;
        gie = 1'b1;
        inst_boundary = 1'b1;
        step();
        chk("p_detect", 32'(irq_detect), 32'd1);
        chk("p_num", 32'(irq_num), 32'd5);
        gie = 1'b0;
        step();
        chk("p_detect_1cyc", 32'(irq_detect), 32'd0);
        chk("p_no_acc_fetch", 32'(irq_acc), 32'd0);
        step();
        vec_ack = 1'b1;
        step();
        chk("p_acc", 32'(irq_acc), 32'h0020);
        vec_ack = 1'b0;
        irq_in = '0;
        step();
        chk("p_acc_1cyc", 32'(irq_acc), 32'd0);
        chk("p_no_redetect", 32'(irq_detect), 32'd0);

        // Masked request held 50 cycles, then gie rises
        irq_in = 14'h0008;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (irq_detect !== 1'b0) bad++;
        end
        chk("m_masked", 32'(bad), 32'd0);
        gie = 1'b1;
        step();
        chk("m_detect", 32'(irq_detect), 32'd1);
        chk("m_num", 32'(irq_num), 32'd3);
        gie = 1'b0;
        irq_in = '0;
        step();
        vec_ack = 1'b1;
        step();
        chk("m_acc_latched", 32'(irq_acc), 32'h0008);
        vec_ack = 1'b0;
        step();
`ifdef SANCUS_IRQ_LAT_MON_EN
        chk("m_latmax", 32'(irq_lat_max), 32'd50);
`else
        chk("m_latmax", 32'(irq_lat_max), 32'd0);
`endif

        // Violation, non-maskable, waits for inst_boundary
        inst_boundary = 1'b0;
        atom_violation = 1'b1;
        step();
        atom_violation = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (irq_detect !== 1'b0) bad++;
        end
        chk("v_no_boundary", 32'(bad), 32'd0);
        inst_boundary = 1'b1;
        step();
        chk("v_detect", 32'(irq_detect), 32'd1);
        chk("v_num", 32'(irq_num), 32'd14);
        step();
        vec_ack = 1'b1;
        step();
        chk("v_acc_none", 32'(irq_acc), 32'd0);
        vec_ack = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (irq_detect !== 1'b0) bad++;
        end
        chk("v_pend_cleared", 32'(bad), 32'd0);

        // Watchdog abort on irq 7
        irq_in = 14'h0080;
        gie = 1'b1;
        step();
        chk("w_detect", 32'(irq_detect), 32'd1);
        chk("w_num", 32'(irq_num), 32'd7);
        gie = 1'b0;
        step();
        bad = 0;
        for (int k = 1; k < 15; k++) begin
            step();
            if (fetch_err !== 1'b0 || irq_acc !== '0) bad++;
        end
        chk("w_early", 32'(bad), 32'd0);
        step();
        chk("w_ferr", 32'(fetch_err), 32'd1);
        chk("w_ferr_noacc", 32'(irq_acc), 32'd0);
        step();
        chk("w_ferr_1cyc", 32'(fetch_err), 32'd0);
        chk("w_idle_nodet", 32'(irq_detect), 32'd0);
        gie = 1'b1;
        step();
        chk("w_redetect", 32'(irq_detect), 32'd1);
        chk("w_renum", 32'(irq_num), 32'd7);
        gie = 1'b0;
        irq_in = '0;
        step();
        vec_ack = 1'b1;
        step();
        chk("w_reacc", 32'(irq_acc), 32'h0080);
        vec_ack = 1'b0;
        step();

        // Violation re-raised in ACK cycle
        atom_violation = 1'b1;
        step();
        atom_violation = 1'b0;
        step();
        chk("c_detect1", 32'(irq_detect), 32'd1);
        chk("c_num1", 32'(irq_num), 32'd14);
        step();
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        atom_violation = 1'b1;
        step();
        atom_violation = 1'b0;
        step();
        chk("c_detect2", 32'(irq_detect), 32'd1);
        chk("c_num2", 32'(irq_num), 32'd14);
        step();
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (irq_detect !== 1'b0) bad++;
        end
        chk("c_no_third", 32'(bad), 32'd0);

        // Reset mid-FETCH
        irq_in = 14'h0002;
        gie = 1'b1;
        step();
        chk("r_detect", 32'(irq_detect), 32'd1);
        chk("r_num", 32'(irq_num), 32'd1);
        gie = 1'b0;
        irq_in = '0;
        step();
        puc_rst_n = 1'b0;
        #1;
        chk("r_async_num", 32'(irq_num), 32'd0);
        chk("r_async_latmax", 32'(irq_lat_max), 32'd0);
        step();
        puc_rst_n = 1'b1;
        vec_ack = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (irq_acc !== '0 || irq_detect !== 1'b0 || fetch_err !== 1'b0) bad++;
        end
        vec_ack = 1'b0;
        chk("r_no_acc", 32'(bad), 32'd0);
        chk("r_latmax", 32'(irq_lat_max), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
